if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the program counter and drives the synchronous InstructionRAM, which returns data one cycle after the address is presented. Produces the IF/ID pipeline register consumed by the decode stage. Handles decode stalls without losing the in-flight fetch, handles branch/jump redirects by flushing, and stops fetching on the halt word.

---
 rtl/if_stage.sv | 159 +++++++++++++++
 tb/tb_if_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the program counter and drives a synchronous instruction RAM whose data
// returns one cycle after the address. A one-entry skid catches the in-flight
// response while decode is stalled. Redirects flush IF/ID and refetch.
// Fetch stops once HALT_WORD comes back.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        CLOCK,
  input  logic        RESET,
  // instruction RAM
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_data,
  // pipeline control
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  // IF/ID pipeline register
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted
);

  typedef enum logic [0:0] {
    StRun,
    StHalt
  } state_e;

  state_e      state_q, state_d;

  // Fetch bookkeeping
  logic [31:0] pc_q, pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_pc_q, req_pc_d;

  // One-entry skid, used only while decode is stalled
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;

  // IF/ID register
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;

  // Combinational fetch-side signals
  logic [31:0] redirect_target;
  logic        rsp_valid;
  logic [31:0] rsp_pc4;
  logic        hit;
  logic        issue;
  logic [31:0] issue_addr;

  // Response tagging, halt detection and issue decision for this cycle
  always_comb begin
    redirect_target = redirect_pc & ~32'h0000_0003;
    // Once halted, any response still arriving is stale and ignored.
    rsp_valid       = req_valid_q && (state_q == StRun);
    rsp_pc4         = req_pc_q + 32'd4;
    hit             = rsp_valid && (imem_data == HALT_WORD) && !redirect;
    issue           = !RESET && (redirect || ((state_q == StRun) && !stall && !hit));
    if (RESET) begin
      issue_addr = RESET_PC;
    end else if (redirect) begin
      issue_addr = redirect_target;
    end else begin
      issue_addr = pc_q;
    end
  end

  assign imem_en   = issue;
  assign imem_addr = {2'b00, issue_addr[31:2]};

  // Next-state for pc, outstanding request, skid, IF/ID and FSM
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_valid_d   = 1'b0;
    req_pc_d      = req_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc4_d    = skid_pc4_q;
    if_id_valid_d = if_id_valid_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;

    if (issue) begin
      req_valid_d = 1'b1;
      req_pc_d    = issue_addr;
      pc_d        = issue_addr + 32'd4;
    end

    if (redirect) begin
      // Flush everything downstream; the in-flight response is simply dropped.
      if_id_valid_d = 1'b0;
      skid_valid_d  = 1'b0;
      state_d       = StRun;
    end else begin
      if (hit) begin
        state_d = StHalt;
      end
      if (stall) begin
        // No fetch issues while stalled, so the skid is always empty here.
        if (rsp_valid) begin
          skid_valid_d = 1'b1;
          skid_instr_d = imem_data;
          skid_pc4_d   = rsp_pc4;
        end
      end else if (skid_valid_q) begin
        if_id_valid_d = 1'b1;
        if_id_instr_d = skid_instr_q;
        if_id_pc4_d   = skid_pc4_q;
        skid_valid_d  = 1'b0;
      end else begin
        if_id_valid_d = rsp_valid;
        if (rsp_valid) begin
          if_id_instr_d = imem_data;
          if_id_pc4_d   = rsp_pc4;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      req_valid_q   <= 1'b0;
      req_pc_q      <= RESET_PC;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= 32'h0;
      skid_pc4_q    <= 32'h0;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= 32'h0;
      if_id_pc4_q   <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_valid_q   <= req_valid_d;
      req_pc_q      <= req_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc4_q    <= skid_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
    end
  end

  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_valid = if_id_valid_q;
  assign halted      = (state_q == StHalt);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural synchronous instruction RAM.
module tb_if_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;

  logic [31:0] mem [0:63];
  int tests = 0;
  int fails = 0;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .HALT_WORD(HALT)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .imem_data  (imem_data),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .if_id_instr(if_id_instr),
    .if_id_pc4  (if_id_pc4),
    .if_id_valid(if_id_valid),
    .halted     (halted)
  );

  always #5 CLOCK = ~CLOCK;

  // Synchronous RAM: data one cycle after an enabled address
  always @(posedge CLOCK) begin
    if (imem_en) imem_data <= mem[imem_addr[5:0]];
  end

  function automatic logic [31:0] w(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hold reset two edges, release; returns #1 after the edge, in cycle 0 of the run.
  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    #1;
  endtask

  // Check the IF/ID register just after an edge.
  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] instr,
                          input logic [31:0] pc4);
    chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, v});
    chk({tag, ".instr"}, if_id_instr, instr);
    chk({tag, ".pc4"}, if_id_pc4, pc4);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = w(i);
    RESET = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // ---------------- reset values ----------------
    tick();
    tick();
    chk("rst.en", {31'h0, imem_en}, 32'h0);
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.halted", {31'h0, halted}, 32'h0);
    chk_ifid("rst", 1'b0, 32'h0, 32'h0);

    // ---------------- stream + 3-cycle stall ----------------
    RESET = 1'b0;
    #1;
    chk("c0.en", {31'h0, imem_en}, 32'h1);
    chk("c0.addr", imem_addr, 32'h0);
    tick();                                   // edge1
    chk("e1.valid", {31'h0, if_id_valid}, 32'h0);
    chk("c1.addr", imem_addr, 32'h1);
    tick();                                   // edge2
    chk_ifid("A", 1'b1, w(0), 32'd4);
    tick();                                   // edge3
    chk_ifid("B", 1'b1, w(1), 32'd8);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall.en", {31'h0, imem_en}, 32'h0);
      chk_ifid("stall.hold", 1'b1, w(1), 32'd8);
      tick();
    end
    stall = 1'b0;
    #1;
    chk_ifid("stall.after", 1'b1, w(1), 32'd8);
    chk("release.en", {31'h0, imem_en}, 32'h1);
    chk("release.addr", imem_addr, 32'd3);
    tick();
    chk_ifid("C", 1'b1, w(2), 32'd12);
    tick();
    chk_ifid("D", 1'b1, w(3), 32'd16);

    // ---------------- redirect while C is in flight ----------------
    do_reset();
    tick(); tick(); tick();                   // edge3: B in IF/ID, C in flight
    chk_ifid("rd.B", 1'b1, w(1), 32'd8);
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    #1;
    chk("rd.en", {31'h0, imem_en}, 32'h1);
    chk("rd.addr", imem_addr, 32'h10);
    tick();
    redirect = 1'b0;
    chk("rd.bubble", {31'h0, if_id_valid}, 32'h0);
    tick();
    chk_ifid("rd.tgt", 1'b1, w(16), 32'h44);
    tick();
    chk_ifid("rd.tgt1", 1'b1, w(17), 32'h48);

    // ---------------- redirect and stall together ----------------
    do_reset();
    tick(); tick(); tick();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0082;  // low bits ignored
    #1;
    chk("rs.en", {31'h0, imem_en}, 32'h1);
    chk("rs.addr", imem_addr, 32'h20);
    tick();
    stall = 1'b0; redirect = 1'b0;
    chk("rs.flush", {31'h0, if_id_valid}, 32'h0);
    tick();
    chk_ifid("rs.tgt", 1'b1, w(32), 32'h84);
    tick();
    chk_ifid("rs.tgt1", 1'b1, w(33), 32'h88);

    // ---------------- reset mid-stall with skid full ----------------
    do_reset();
    tick(); tick(); tick();                   // B in IF/ID
    stall = 1'b1;
    tick();                                   // C now in skid
    RESET = 1'b1;
    #1;
    chk("mr.en", {31'h0, imem_en}, 32'h0);
    tick();
    chk_ifid("mr", 1'b0, 32'h0, 32'h0);
    chk("mr.addr", imem_addr, 32'h0);
    RESET = 1'b0; stall = 1'b0;
    #1;
    chk("mr.en1", {31'h0, imem_en}, 32'h1);
    chk("mr.addr1", imem_addr, 32'h0);
    tick();
    chk("mr.skidclr", {31'h0, if_id_valid}, 32'h0);
    tick();
    chk_ifid("mr.A", 1'b1, w(0), 32'd4);

    // ---------------- pc wrap ----------------
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("wr.addr", imem_addr, 32'h3FFF_FFFF);
    tick();
    redirect = 1'b0;
    #1;
    chk("wr.en", {31'h0, imem_en}, 32'h1);
    chk("wr.addr0", imem_addr, 32'h0);
    tick();
    chk_ifid("wr.top", 1'b1, w(63), 32'h0);
    tick();
    chk_ifid("wr.w0", 1'b1, w(0), 32'd4);

    // ---------------- halt word at word 5 ----------------
    mem[5] = HALT;
    do_reset();
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();                                 // edges 2..6
      chk_ifid($sformatf("h.w%0d", k), 1'b1, w(k), 32'(4 * (k + 1)));
      chk("h.run", {31'h0, halted}, 32'h0);
    end
    chk("h.hit.en", {31'h0, imem_en}, 32'h0);
    tick();                                   // edge7
    chk_ifid("h.halt", 1'b1, HALT, 32'd24);
    chk("h.halted", {31'h0, halted}, 32'h1);
    chk("h.en7", {31'h0, imem_en}, 32'h0);
    tick();
    chk("h.drain", {31'h0, if_id_valid}, 32'h0);
    chk("h.en8", {31'h0, imem_en}, 32'h0);
    tick();
    chk("h.en9", {31'h0, imem_en}, 32'h0);
    chk("h.still", {31'h0, halted}, 32'h1);
    redirect = 1'b1; redirect_pc = 32'h0;
    #1;
    chk("h.rd.en", {31'h0, imem_en}, 32'h1);
    chk("h.rd.addr", imem_addr, 32'h0);
    tick();
    redirect = 1'b0;
    chk("h.cleared", {31'h0, halted}, 32'h0);
    chk("h.bubble", {31'h0, if_id_valid}, 32'h0);
    tick();
    chk_ifid("h.restart", 1'b1, w(0), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
